instruction_fetch_unit: RTL

IF-stage initiator for the pipeline's instruction memory. It owns the program counter, drives the word address to the instruction memory, captures the returned 32-bit instruction into the IF/ID pipeline register, and handles stall, branch redirect/flush, and end-of-program halt. It sits between the hazard/branch logic and the decode stage.

---
 rtl/instruction_fetch_unit.sv | 89 ++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: IF stage owning the PC, driving instruction memory and loading the IF/ID register
// Ports: clk/rst (async active-high); stall holds PC and IF/ID; branch_taken/branch_target redirect and flush;
//        instruction_in is the zero-latency memory read data; imem_address = PC; if_id_* is the IF/ID register;
//        halted is high in HALT. Optional FETCH_PERF_COUNT_EN adds fetch_count (captured-instruction count).
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter logic [31:0] MEM_DEPTH = 32'd7,
    parameter logic [31:0] PC_INCR   = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] instruction_in,
    output logic [31:0] imem_address,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc_plus1,
    output logic        if_id_valid,
`ifdef FETCH_PERF_COUNT_EN
    output logic [31:0] fetch_count,
`endif
    output logic        halted
);
    typedef enum logic {RUN, HALT} state_t;
    state_t      r_state, w_state_next;
    logic [31:0] r_pc, w_pc_next, w_pc_inc;
    logic [31:0] r_instr, w_instr_next;
    logic [31:0] r_pc1, w_pc1_next;
    logic        r_valid, w_valid_next;
    assign w_pc_inc          = r_pc + PC_INCR;
    assign imem_address      = r_pc;
    assign if_id_instruction = r_instr;
    assign if_id_pc_plus1    = r_pc1;
    assign if_id_valid       = r_valid;
    assign halted            = (r_state == HALT);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_pc1   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_instr <= w_instr_next;
            r_pc1   <= w_pc1_next;
            r_valid <= w_valid_next;
        end
    end
    // Priority: branch flush > stall hold > HALT bubble > normal fetch.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_instr_next = r_instr;
        w_pc1_next   = r_pc1;
        w_valid_next = r_valid;
        if (branch_taken) begin
            w_pc_next    = branch_target;
            w_instr_next = '0;
            w_pc1_next   = '0;
            w_valid_next = 1'b0;
            w_state_next = (branch_target >= MEM_DEPTH) ? HALT : RUN;
        end else if (!stall) begin
            if (r_state == HALT) begin
                w_instr_next = '0;
                w_pc1_next   = '0;
                w_valid_next = 1'b0;
            end else begin
                w_instr_next = instruction_in;
                w_pc1_next   = w_pc_inc;
                w_valid_next = 1'b1;
                w_pc_next    = w_pc_inc;
                w_state_next = (w_pc_inc >= MEM_DEPTH) ? HALT : RUN;
            end
        end
    end
`ifdef FETCH_PERF_COUNT_EN
    logic        w_capture;
    logic [31:0] r_fetch_count;
    assign w_capture   = !branch_taken && !stall && (r_state == RUN);
    assign fetch_count = r_fetch_count;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_fetch_count <= '0;
        else if (w_capture) r_fetch_count <= r_fetch_count + 32'd1;
    end
`endif
endmodule
